perceptron_dot_seq: RTL and testbench

Sequential perceptron neuron datapath in signed Q32.32 fixed point (64-bit, 32 fractional bits). It consumes a stream of (x, w) feature/weight pairs one per cycle and accumulates their fixed-point products. It then adds a bias and emits the weighted sum plus a step-activation class bit. It sits between the feature/weight source and the classifier/training-update logic.

---
 rtl/perceptron_dot_seq.sv | 114 +++++++++++
 tb/tb_perceptron_dot_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_dot_seq.sv
// Sequential perceptron neuron: accumulates signed Q32.32 x*w products per vector,
// adds a bias and presents the weighted sum with a step-activation class bit.
module perceptron_dot_seq #(
    parameter int N_INPUTS  = 4,
    parameter int FRAC_BITS = 32,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_x,
    input  logic [63:0] in_w,
    input  logic        in_last,
    input  logic [63:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_class,
    output logic        out_len_err
);

    typedef enum logic [1:0] {
        ACCUM,
        BIAS,
        OUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [63:0]        acc;
    logic [CNT_W-1:0]   count;
    logic signed [127:0] x_ext;
    logic signed [127:0] w_ext;
    logic signed [127:0] prod;
    logic [63:0]        mul_res;
    logic [63:0]        biased;
    logic               beat;

    // Full-width signed product, then floor-shift back to Q32.32 with silent wrap.
    always_comb begin
        x_ext   = {{64{in_x[63]}}, in_x};
        w_ext   = {{64{in_w[63]}}, in_w};
        prod    = x_ext * w_ext;
        mul_res = 64'(prod >>> FRAC_BITS);
        biased  = acc + bias;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        beat      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                beat     = in_valid;
                if (in_valid && in_last) begin
                    state_nxt = BIAS;
                end
            end
            BIAS: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            acc         <= '0;
            count       <= '0;
            out_sum     <= '0;
            out_class   <= 1'b0;
            out_len_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc + mul_res;
                        count <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
                    end
                end
                BIAS: begin
                    out_sum     <= biased;
                    out_class   <= ~biased[63];
                    out_len_err <= (count != CNT_W'(N_INPUTS));
                end
                OUT: begin
                    // Results stay held after the handshake; only the accumulator restarts.
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: begin
                    acc   <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_dot_seq.sv
// Self-checking bench for perceptron_dot_seq: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for each directed scenario.
module tb_perceptron_dot_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_x;
    logic [63:0] in_w;
    logic        in_last;
    logic [63:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_class;
    logic        out_len_err;

    int checks = 0;
    int errors = 0;

    perceptron_dot_seq #(.N_INPUTS(N), .FRAC_BITS(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_last(in_last),
        .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_class(out_class), .out_len_err(out_len_err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ONE    = 64'h0000_0001_0000_0000;
    localparam logic [63:0] TWO    = 64'h0000_0002_0000_0000;
    localparam logic [63:0] NEG3   = 64'hFFFF_FFFD_0000_0000;
    localparam logic [63:0] HALF   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] QUART  = 64'h0000_0000_4000_0000;
    localparam logic [63:0] B075   = 64'h0000_0000_C000_0000;

    // Real-valued product scaled by 2^-32, floored: middle 64 bits of the 128-bit product.
    function automatic logic [63:0] qmul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] p;
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return p[95:32];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [63:0] m_acc;
    int          m_cnt;
    bit          m_busy  = 1'b0;
    bit          m_shown = 1'b0;
    bit          m_live  = 1'b0;
    logic [63:0] m_sum;
    bit          m_class;
    bit          m_err;

    // Transaction model: a vector completes on its last beat, the result shows one cycle later
    // and is retired by a handshake; no pairs are taken while a result is pending.
    always @(posedge clk) begin
        if (rst) begin
            m_acc = '0; m_cnt = 0; m_busy = 0; m_shown = 0; m_live = 1;
            m_sum = '0; m_class = 0; m_err = 0;
        end else if (m_live) begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_acc = m_acc + qmul(in_x, in_w);
                    m_cnt++;
                    if (in_last) begin
                        m_sum   = m_acc + bias;
                        m_class = (m_sum[63] == 1'b0);
                        m_err   = (m_cnt != N);
                        m_busy  = 1; m_shown = 0;
                        m_acc   = '0; m_cnt = 0;
                    end
                end
            end else if (!m_shown) begin
                m_shown = 1;
            end else if (out_ready) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("m_in_ready", 64'(in_ready), 64'(!m_busy));
            checkOutput("m_out_valid", 64'(out_valid), 64'(m_busy && m_shown));
            if (!m_busy || m_shown) begin
                checkOutput("m_out_sum", out_sum, m_sum);
                checkOutput("m_out_class", 64'(out_class), 64'(m_class));
                checkOutput("m_out_len_err", 64'(out_len_err), 64'(m_err));
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] w, input logic last);
        in_valid = 1'b1; in_x = x; in_w = w; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic sendNominal();
        applyStimulus(ONE, HALF, 1'b0);
        applyStimulus(TWO, QUART, 1'b0);
        applyStimulus(NEG3, ONE, 1'b0);
        applyStimulus(HALF, TWO, 1'b1);
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; in_last = 1'b0;
        bias = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_sum", out_sum, 64'd0);

        // Nominal vector with exact latency pinned.
        bias = B075;
        sendNominal();
        checkOutput("lat_bias_cycle", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("lat_valid", 64'(out_valid), 64'd1);
        checkOutput("nom_sum", out_sum, 64'hFFFF_FFFF_C000_0000);
        checkOutput("nom_class", 64'(out_class), 64'd0);
        checkOutput("nom_len_err", 64'(out_len_err), 64'd0);
        handshake();
        checkOutput("nom_in_ready_after", 64'(in_ready), 64'd1);

        // Zero boundary counts as positive; out_ready held high.
        bias = ONE;
        out_ready = 1'b1;
        sendNominal();
        waitValid("zero");
        checkOutput("zero_sum", out_sum, 64'd0);
        checkOutput("zero_class", 64'(out_class), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;

        // Floor rounding of -1 LSB and a product that wraps to zero.
        bias = '0;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, HALF, 1'b0);
        applyStimulus(64'h4000_0000_0000_0000, 64'h0000_0004_0000_0000, 1'b1);
        waitValid("round");
        checkOutput("round_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("round_class", 64'(out_class), 64'd0);
        checkOutput("round_len_err", 64'(out_len_err), 64'd1);

        // Backpressure with beats offered that must be refused.
        in_valid = 1'b1; in_x = ONE; in_w = ONE; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake();
        checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);

        // Short vector: three beats.
        bias = B075;
        applyStimulus(ONE, HALF, 1'b0);
        applyStimulus(TWO, QUART, 1'b0);
        applyStimulus(NEG3, ONE, 1'b1);
        waitValid("short");
        checkOutput("short_sum", out_sum, 64'hFFFF_FFFE_C000_0000);
        checkOutput("short_len_err", 64'(out_len_err), 64'd1);
        handshake();

        // Long vector: five beats.
        applyStimulus(ONE, HALF, 1'b0);
        applyStimulus(TWO, QUART, 1'b0);
        applyStimulus(NEG3, ONE, 1'b0);
        applyStimulus(HALF, TWO, 1'b0);
        applyStimulus(ONE, ONE, 1'b1);
        waitValid("long");
        checkOutput("long_sum", out_sum, B075);
        checkOutput("long_class", 64'(out_class), 64'd1);
        checkOutput("long_len_err", 64'(out_len_err), 64'd1);
        handshake();

        // Reset mid-vector discards the partial sum.
        applyStimulus(64'h0000_0005_0000_0000, 64'h0000_0003_0000_0000, 1'b0);
        applyStimulus(64'h0000_0005_0000_0000, 64'h0000_0003_0000_0000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstmid_sum", out_sum, 64'd0);
        checkOutput("rstmid_class", 64'(out_class), 64'd0);
        checkOutput("rstmid_in_ready", 64'(in_ready), 64'd1);
        sendNominal();
        waitValid("after_rst");
        checkOutput("after_rst_sum", out_sum, 64'hFFFF_FFFF_C000_0000);
        handshake();

        // Reset while a result is held under backpressure.
        sendNominal();
        waitValid("rstout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstout_valid", 64'(out_valid), 64'd0);
        checkOutput("rstout_sum", out_sum, 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
